id_ex_reg_ctl: RTL and testbench
================================

// Module: id_ex_reg_ctl
// PURPOSE
//   Parametrised ID->EX pipeline register with stall, bubble insertion and flush control.
//   Sits between decode and execute and is driven by the central stall controller.
//   Adds a valid bit and a saturating bubble-cycle counter that feeds the performance registers.
// PARAMETERS
//   ALUOP_W   8   width of ALU operation code
//   ALUSEL_W  3   width of ALU result-select code
//   DATA_W    32  operand width
//   RADDR_W   5   destination register address width
//   STALL_W   6   width of stall vector from controller (bit0=PC ... bit5=WB)
//   ID_IDX    2   stall-vector bit index of ID stage; EX index is ID_IDX+1
//   CNT_W     16  bubble counter width
// PORTS
//   clk             in   1         clock, rising edge
//   rst             in   1         asynchronous reset, active-high
//   stall           in   STALL_W   per-stage hold request from controller
//   flush           in   1         kill in-flight instruction (exception/branch redirect)
//   id_valid        in   1         decode holds a real instruction
//   id_aluop        in   ALUOP_W   decoded ALU op
//   id_alusel       in   ALUSEL_W  decoded result select
//   id_reg1         in   DATA_W    operand 1
//   id_reg2         in   DATA_W    operand 2
//   id_wd           in   RADDR_W   destination register
//   id_wreg         in   1         destination write enable
//   ex_valid        out  1         EX holds a real instruction
//   ex_aluop/ex_alusel/ex_reg1/ex_reg2/ex_wd/ex_wreg  out  (matching widths)  registered payload
//   bubble_cnt      out  CNT_W     saturating count of bubble cycles inserted
//   cnt_clr         in   1         synchronous clear of bubble_cnt
// BEHAVIOUR
//   - Reset (async, rst=1): all ex_* = 0 (NOP op, NOP sel, zero operands, reg 0, wreg=0), ex_valid=0, bubble_cnt=0.
//   - Latency 1 cycle; all outputs registered, no combinational path input->output.
//   - Per rising edge, priority high->low:
//     1. flush=1: load NOP payload, ex_valid=0 (overrides any stall).
//     2. stall[ID_IDX]=1 & stall[ID_IDX+1]=0: load NOP payload, ex_valid=0, bubble_cnt += 1.
//     3. stall[ID_IDX]=0: load id_* payload, ex_valid=id_valid; if id_valid=0 force ex_wreg=0.
//     4. otherwise (both stalled): hold all ex_* and ex_valid.
//   - bubble_cnt: saturates at all-ones, never wraps; cnt_clr=1 zeroes it that cycle and wins over increment.
//     Flush cycles are not counted.
//   - ex_wreg is never 1 while ex_valid=0 (invariant).
//   - stall bits other than ID_IDX and ID_IDX+1 are ignored.
//   - Reset asserted mid-stall discards held payload; first post-reset edge follows rule 1-4 normally.
// CONFIGURATION
//   ID_EX_DELAYSLOT_EN defined: adds in ports id_is_in_delayslot(1), id_link_addr(DATA_W),
//     id_next_inst_in_delayslot(1); out ports ex_is_in_delayslot(1), ex_link_addr(DATA_W),
//     is_in_delayslot_o(1). These register/hold/clear under rules 1-4 like the payload; is_in_delayslot_o
//     is a registered copy of id_next_inst_in_delayslot, updated only on rule 3, cleared on rules 1/2.
//   Not defined: ports absent, no delay-slot state.
// STRUCTURE
//   - NOP op/sel codes, zero word, NOP reg address and write-enable/disable levels from the shared defines
//     (extend defines.v; no local literals).
//   - Stall-index constants (STALL_PC..STALL_WB) added to the shared defines.
//   - One sub-module: sat_counter (width CNT_W, inc, clr, async rst) for bubble_cnt; payload register inline.
// TESTING
//   1. rst=1 with nonzero id_* -> all ex_* = 0, ex_valid=0, bubble_cnt=0; outputs drop immediately on rst rise (async).
//   2. stall=0, id_valid=1, aluop=0x21, reg1=0x1234_5678, wd=5, wreg=1 -> next edge ex_* equal inputs, ex_valid=1.
//   3. stall=6'b000100 for 3 cycles -> ex_* NOP, ex_valid=0, bubble_cnt=3; stall=6'b001100 -> ex_* held, count unchanged.
//   4. flush=1 with stall=6'b000100 -> NOP loaded, bubble_cnt unchanged; flush=1 with stall=0 -> NOP, ex_valid=0.
//   5. CNT_W=4, 20 bubble cycles -> bubble_cnt stops at 15; cnt_clr=1 with bubble -> bubble_cnt=0.
//   6. ID_EX_DELAYSLOT_EN: id_next_inst_in_delayslot=1, stall=0 -> is_in_delayslot_o=1 next edge; flush -> 0.

Source files
------------

// File: rtl/id_ex_reg_ctl_pkg.sv
// Shared constants for the ID->EX register: NOP payload codes, write-enable
// levels, stall-vector stage indices, and the per-edge action decode.
package id_ex_reg_ctl_pkg;

    // NOP payload codes and neutral values
    localparam logic [7:0]  EXE_NOP_OP    = 8'b0000_0000;
    localparam logic [2:0]  EXE_RES_NOP   = 3'b000;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam logic [4:0]  NOP_REG_ADDR  = 5'b00000;
    localparam logic        WRITE_ENABLE  = 1'b1;
    localparam logic        WRITE_DISABLE = 1'b0;

    // Stall vector bit positions, front to back of the pipe
    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    // What the register does on the next rising edge
    typedef enum logic [1:0] {
        ACT_FLUSH  = 2'd0,
        ACT_BUBBLE = 2'd1,
        ACT_LOAD   = 2'd2,
        ACT_HOLD   = 2'd3
    } ex_act_e;

    // Flush beats everything; an ID stall with EX free inserts a bubble;
    // ID free loads; both stalled holds.
    function automatic ex_act_e id_ex_decide(input logic flush,
                                             input logic id_stall,
                                             input logic ex_stall);
        ex_act_e act;
        if (flush)
            act = ACT_FLUSH;
        else if (id_stall && !ex_stall)
            act = ACT_BUBBLE;
        else if (!id_stall)
            act = ACT_LOAD;
        else
            act = ACT_HOLD;
        return act;
    endfunction

endpackage

// File: rtl/id_ex_reg_ctl_if.sv
// Decode/execute payload bundle. master = decode side (drives id_*),
// slave = the pipeline register (drives ex_*).
// Optional delay-slot fields exist only when ID_EX_DELAYSLOT_EN is defined.
interface id_ex_reg_ctl_if #(
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3,
    parameter int DATA_W   = 32,
    parameter int RADDR_W  = 5
);
    logic                id_valid;
    logic [ALUOP_W-1:0]  id_aluop;
    logic [ALUSEL_W-1:0] id_alusel;
    logic [DATA_W-1:0]   id_reg1;
    logic [DATA_W-1:0]   id_reg2;
    logic [RADDR_W-1:0]  id_wd;
    logic                id_wreg;

    logic                ex_valid;
    logic [ALUOP_W-1:0]  ex_aluop;
    logic [ALUSEL_W-1:0] ex_alusel;
    logic [DATA_W-1:0]   ex_reg1;
    logic [DATA_W-1:0]   ex_reg2;
    logic [RADDR_W-1:0]  ex_wd;
    logic                ex_wreg;

`ifdef ID_EX_DELAYSLOT_EN
    logic                id_is_in_delayslot;
    logic [DATA_W-1:0]   id_link_addr;
    logic                id_next_inst_in_delayslot;
    logic                ex_is_in_delayslot;
    logic [DATA_W-1:0]   ex_link_addr;
    logic                is_in_delayslot_o;

    modport master (
        output id_valid, id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg,
        output id_is_in_delayslot, id_link_addr, id_next_inst_in_delayslot,
        input  ex_valid, ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg,
        input  ex_is_in_delayslot, ex_link_addr, is_in_delayslot_o
    );
    modport slave (
        input  id_valid, id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg,
        input  id_is_in_delayslot, id_link_addr, id_next_inst_in_delayslot,
        output ex_valid, ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg,
        output ex_is_in_delayslot, ex_link_addr, is_in_delayslot_o
    );
`else
    modport master (
        output id_valid, id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg,
        input  ex_valid, ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg
    );
    modport slave (
        input  id_valid, id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg,
        output ex_valid, ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg
    );
`endif

endinterface

// File: rtl/id_ex_reg_ctl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment)
// and asynchronous active-high reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    // Count up on inc, stick at all-ones, clear on request
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && (count != {CNT_W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/id_ex_reg_ctl.sv
// ID->EX pipeline register with flush, bubble insertion and hold, plus a
// saturating bubble-cycle counter. Delay-slot fields are built only when
// ID_EX_DELAYSLOT_EN is defined.
module id_ex_reg_ctl
    import id_ex_reg_ctl_pkg::*;
#(
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3,
    parameter int DATA_W   = 32,
    parameter int RADDR_W  = 5,
    parameter int STALL_W  = 6,
    parameter int ID_IDX   = STALL_ID,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   bubble_cnt,
    id_ex_reg_ctl_if.slave     bus
);

    ex_act_e act;

    // Only the ID and EX stall bits matter; the rest are folded here so they
    // are visibly consumed.
    logic unused_stall;
    assign unused_stall = ^stall;

    // Decide this edge's action from flush and the two relevant stall bits
    always_comb begin
        act = id_ex_decide(flush, stall[ID_IDX], stall[ID_IDX+1]);
    end

    // Payload register: NOP on flush/bubble, load on ID free, else hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ex_valid  <= 1'b0;
            bus.ex_aluop  <= ALUOP_W'(EXE_NOP_OP);
            bus.ex_alusel <= ALUSEL_W'(EXE_RES_NOP);
            bus.ex_reg1   <= DATA_W'(ZERO_WORD);
            bus.ex_reg2   <= DATA_W'(ZERO_WORD);
            bus.ex_wd     <= RADDR_W'(NOP_REG_ADDR);
            bus.ex_wreg   <= WRITE_DISABLE;
        end else begin
            case (act)
                ACT_FLUSH, ACT_BUBBLE: begin
                    bus.ex_valid  <= 1'b0;
                    bus.ex_aluop  <= ALUOP_W'(EXE_NOP_OP);
                    bus.ex_alusel <= ALUSEL_W'(EXE_RES_NOP);
                    bus.ex_reg1   <= DATA_W'(ZERO_WORD);
                    bus.ex_reg2   <= DATA_W'(ZERO_WORD);
                    bus.ex_wd     <= RADDR_W'(NOP_REG_ADDR);
                    bus.ex_wreg   <= WRITE_DISABLE;
                end
                ACT_LOAD: begin
                    bus.ex_valid  <= bus.id_valid;
                    bus.ex_aluop  <= bus.id_aluop;
                    bus.ex_alusel <= bus.id_alusel;
                    bus.ex_reg1   <= bus.id_reg1;
                    bus.ex_reg2   <= bus.id_reg2;
                    bus.ex_wd     <= bus.id_wd;
                    // A non-instruction must never write the register file
                    bus.ex_wreg   <= bus.id_valid ? bus.id_wreg : WRITE_DISABLE;
                end
                default: ;
            endcase
        end
    end

`ifdef ID_EX_DELAYSLOT_EN
    // Delay-slot fields follow the same flush/bubble/load/hold rules
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ex_is_in_delayslot <= 1'b0;
            bus.ex_link_addr       <= DATA_W'(ZERO_WORD);
            bus.is_in_delayslot_o  <= 1'b0;
        end else begin
            case (act)
                ACT_FLUSH, ACT_BUBBLE: begin
                    bus.ex_is_in_delayslot <= 1'b0;
                    bus.ex_link_addr       <= DATA_W'(ZERO_WORD);
                    bus.is_in_delayslot_o  <= 1'b0;
                end
                ACT_LOAD: begin
                    bus.ex_is_in_delayslot <= bus.id_is_in_delayslot;
                    bus.ex_link_addr       <= bus.id_link_addr;
                    bus.is_in_delayslot_o  <= bus.id_next_inst_in_delayslot;
                end
                default: ;
            endcase
        end
    end
`endif

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (act == ACT_BUBBLE),
        .clr   (cnt_clr),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_id_ex_reg_ctl.sv
// Directed bench for id_ex_reg_ctl (CNT_W=4 so saturation is reachable).
// Exercises the delay-slot fields when ID_EX_DELAYSLOT_EN is defined.
module tb_id_ex_reg_ctl;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [5:0]       stall;
    logic             flush;
    logic             cnt_clr;
    logic [CNT_W-1:0] bubble_cnt;

    int n_total = 0;
    int n_pass  = 0;

    id_ex_reg_ctl_if #(.ALUOP_W(8), .ALUSEL_W(3), .DATA_W(32), .RADDR_W(5)) bus ();

    id_ex_reg_ctl #(
        .ALUOP_W (8), .ALUSEL_W (3), .DATA_W (32), .RADDR_W (5),
        .STALL_W (6), .ID_IDX (2), .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .cnt_clr    (cnt_clr),
        .bubble_cnt (bubble_cnt),
        .bus        (bus.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // one clock edge, then settle away from the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [7:0] op, input logic [2:0] sel,
                            input logic [31:0] r1, input logic [31:0] r2,
                            input logic [4:0] wd, input logic wr);
        bus.id_valid  = v;
        bus.id_aluop  = op;
        bus.id_alusel = sel;
        bus.id_reg1   = r1;
        bus.id_reg2   = r2;
        bus.id_wd     = wd;
        bus.id_wreg   = wr;
    endtask

    task automatic check_ex(input string tag, input logic v, input logic [7:0] op,
                            input logic [2:0] sel, input logic [31:0] r1, input logic [31:0] r2,
                            input logic [4:0] wd, input logic wr);
        check({tag, ".valid"}, 32'(bus.ex_valid), 32'(v));
        check({tag, ".aluop"}, 32'(bus.ex_aluop), 32'(op));
        check({tag, ".alusel"}, 32'(bus.ex_alusel), 32'(sel));
        check({tag, ".reg1"}, bus.ex_reg1, r1);
        check({tag, ".reg2"}, bus.ex_reg2, r2);
        check({tag, ".wd"}, 32'(bus.ex_wd), 32'(wd));
        check({tag, ".wreg"}, 32'(bus.ex_wreg), 32'(wr));
    endtask

    initial begin
        rst     = 1'b1;
        stall   = 6'b000000;
        flush   = 1'b0;
        cnt_clr = 1'b0;
        drive_id(1'b1, 8'h21, 3'd2, 32'h1234_5678, 32'hDEAD_BEEF, 5'd5, 1'b1);
`ifdef ID_EX_DELAYSLOT_EN
        bus.id_is_in_delayslot        = 1'b1;
        bus.id_link_addr              = 32'h0000_0040;
        bus.id_next_inst_in_delayslot = 1'b1;
`endif

        // reset holds everything at zero despite live inputs
        step();
        step();
        check_ex("reset", 1'b0, 8'h00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0);
        check("reset.cnt", 32'(bubble_cnt), 32'd0);

        // plain load
        rst = 1'b0;
        step();
        check_ex("load", 1'b1, 8'h21, 3'd2, 32'h1234_5678, 32'hDEAD_BEEF, 5'd5, 1'b1);

        // reset is asynchronous: outputs drop without a clock edge
        rst = 1'b1;
        #1;
        check("async_rst.valid", 32'(bus.ex_valid), 32'd0);
        check("async_rst.aluop", 32'(bus.ex_aluop), 32'd0);
        rst = 1'b0;

        // reload, then three bubbles
        step();
        check("reload.valid", 32'(bus.ex_valid), 32'd1);
        stall = 6'b000100;
        step();
        step();
        step();
        check_ex("bubble", 1'b0, 8'h00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0);
        check("bubble.cnt", 32'(bubble_cnt), 32'd3);

        // load a new instruction, then hold under both-stall with changed inputs
        stall = 6'b000000;
        drive_id(1'b1, 8'h33, 3'd5, 32'hA5A5_0001, 32'h0000_0F0F, 5'd17, 1'b1);
        step();
        stall = 6'b001100;
        drive_id(1'b1, 8'h44, 3'd1, 32'h1111_1111, 32'h2222_2222, 5'd9, 1'b0);
        step();
        step();
        check_ex("hold", 1'b1, 8'h33, 3'd5, 32'hA5A5_0001, 32'h0000_0F0F, 5'd17, 1'b1);
        check("hold.cnt", 32'(bubble_cnt), 32'd3);

        // flush beats hold
        flush = 1'b1;
        step();
        check_ex("flush_hold", 1'b0, 8'h00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0);

        // flush during a bubble request is not counted
        stall = 6'b000100;
        step();
        check("flush_bubble.cnt", 32'(bubble_cnt), 32'd3);
        check("flush_bubble.valid", 32'(bus.ex_valid), 32'd0);

        // flush with no stall still yields NOP
        stall = 6'b000000;
        step();
        check_ex("flush_free", 1'b0, 8'h00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0);
        flush = 1'b0;

        // invalid instruction: payload loads but write enable is forced low
        drive_id(1'b0, 8'h55, 3'd3, 32'hCAFE_0000, 32'h0000_BABE, 5'd31, 1'b1);
        step();
        check_ex("invalid", 1'b0, 8'h55, 3'd3, 32'hCAFE_0000, 32'h0000_BABE, 5'd31, 1'b0);

        // stall bits outside ID/EX are ignored
        stall = 6'b110011;
        drive_id(1'b1, 8'h66, 3'd4, 32'h0BAD_F00D, 32'h1357_9BDF, 5'd3, 1'b1);
        step();
        check_ex("ignore_bits", 1'b1, 8'h66, 3'd4, 32'h0BAD_F00D, 32'h1357_9BDF, 5'd3, 1'b1);
        check("ignore_bits.cnt", 32'(bubble_cnt), 32'd3);

        // clear wins over a same-cycle bubble
        stall   = 6'b000100;
        cnt_clr = 1'b1;
        step();
        check("clr_bubble.cnt", 32'(bubble_cnt), 32'd0);
        cnt_clr = 1'b0;

        // 20 bubbles saturate a 4-bit counter at 15
        for (int i = 0; i < 20; i++) step();
        check("saturate.cnt", 32'(bubble_cnt), 32'd15);
        cnt_clr = 1'b1;
        step();
        check("clr_sat.cnt", 32'(bubble_cnt), 32'd0);
        cnt_clr = 1'b0;

        // reset during a hold discards the held payload; hold then keeps zeros
        stall = 6'b000000;
        step();
        stall = 6'b001100;
        step();
        check("pre_rst_hold.valid", 32'(bus.ex_valid), 32'd1);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step();
        check_ex("rst_mid_stall", 1'b0, 8'h00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0);

`ifdef ID_EX_DELAYSLOT_EN
        // delay-slot fields load on a free ID stage and clear on flush
        stall = 6'b000000;
        bus.id_is_in_delayslot        = 1'b1;
        bus.id_link_addr              = 32'h0000_0040;
        bus.id_next_inst_in_delayslot = 1'b1;
        step();
        check("ds_load.next", 32'(bus.is_in_delayslot_o), 32'd1);
        check("ds_load.in", 32'(bus.ex_is_in_delayslot), 32'd1);
        check("ds_load.link", bus.ex_link_addr, 32'h0000_0040);
        stall = 6'b001100;
        bus.id_next_inst_in_delayslot = 1'b0;
        step();
        check("ds_hold.next", 32'(bus.is_in_delayslot_o), 32'd1);
        flush = 1'b1;
        step();
        check("ds_flush.next", 32'(bus.is_in_delayslot_o), 32'd0);
        check("ds_flush.link", bus.ex_link_addr, 32'h0);
        flush = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
